// File: rtl/hub75_fb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// hub75_fb_arbiter_pkg
//   Types and helpers used by the frame-buffer arbiter.
//   - owner_e         : which requester held the RAM most recently
//   - reader_wins_tie : alternating-priority decision when both request
// ----------------------------------------------------------------------------
package hub75_fb_arbiter_pkg;

  typedef enum logic {
    OWNER_RD = 1'b0,
    OWNER_WR = 1'b1
  } owner_e;

  // On a simultaneous request the side that did not own the RAM last wins.
  function automatic logic reader_wins_tie(input owner_e last_owner);
    return (last_owner == OWNER_WR);
  endfunction

endpackage

// File: rtl/hub75_fb_arbiter.sv
// ----------------------------------------------------------------------------
// hub75_fb_arbiter
//   Shares the single-port frame-buffer RAM between the row read-out engine
//   and the pixel write port (SPI/DMA loader).
//
//   Each requester raises req, receives a one-cycle gnt pulse in the first
//   cycle it owns the RAM, and ends its session with a one-cycle rel pulse.
//   A one-cycle TURN state separates sessions. Ties alternate between the
//   two sides. While the writer holds the RAM and the reader waits, a counter
//   saturates at WR_MAX_BURST and raises the advisory wr_yield.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   rd_req/rd_gnt/rd_rel   read-out session handshake
//   rd_addr, rd_data       read-out address in, RAM read data out
//   wr_req/wr_gnt/wr_rel   writer session handshake
//   wr_addr, wr_data       writer address and data
//   wr_ena                 writer write strobe (honoured only while it owns)
//   wr_yield               reader has waited too long; writer should release
//   fb_addr/fb_wdata/fb_we RAM request side
//   fb_rdata               RAM read data (1-cycle latency)
// ----------------------------------------------------------------------------
module hub75_fb_arbiter
  import hub75_fb_arbiter_pkg::*;
#(
  parameter int FB_AW        = 13,
  parameter int FB_DW        = 16,
  parameter int WR_MAX_BURST = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_req,
  output logic             rd_gnt,
  input  logic             rd_rel,
  input  logic [FB_AW-1:0] rd_addr,
  output logic [FB_DW-1:0] rd_data,
  input  logic             wr_req,
  output logic             wr_gnt,
  input  logic             wr_rel,
  input  logic [FB_AW-1:0] wr_addr,
  input  logic [FB_DW-1:0] wr_data,
  input  logic             wr_ena,
  output logic             wr_yield,
  output logic [FB_AW-1:0] fb_addr,
  output logic [FB_DW-1:0] fb_wdata,
  output logic             fb_we,
  input  logic [FB_DW-1:0] fb_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_TURN = 2'd3
  } state_e;

  localparam int                HOLD_W   = $clog2(WR_MAX_BURST + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(WR_MAX_BURST);

  state_e              state_reg, state_next;
  owner_e              last_owner_reg, last_owner_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic                rd_gnt_reg, wr_gnt_reg, wr_yield_reg;
  logic                grant_rd, grant_wr;
  logic                yield_next;

  // --------------------------------------------------------------------------
  // Next-state / grant decision
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    grant_rd   = 1'b0;
    grant_wr   = 1'b0;

    unique case (state_reg)
      ST_IDLE, ST_TURN: begin
        if (rd_req && (!wr_req || reader_wins_tie(last_owner_reg))) begin
          grant_rd   = 1'b1;
          state_next = ST_RD;
        end else if (wr_req) begin
          grant_wr   = 1'b1;
          state_next = ST_WR;
        end else begin
          state_next = ST_IDLE;
        end
      end
      // Requests seen while owning are ignored; only the owner's rel counts,
      // including a rel in the grant cycle (zero-length session).
      ST_RD: begin
        if (rd_rel) state_next = ST_TURN;
      end
      ST_WR: begin
        if (wr_rel) state_next = ST_TURN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Owner history, starvation counter, advisory yield
  // --------------------------------------------------------------------------
  always_comb begin
    last_owner_next = last_owner_reg;
    if (grant_rd) begin
      last_owner_next = OWNER_RD;
    end else if (grant_wr) begin
      last_owner_next = OWNER_WR;
    end

    // Counter only lives inside a WR session; leaving WR clears it even if
    // rd_req is high in that last cycle.
    hold_cnt_next = '0;
    if ((state_reg == ST_WR) && (state_next == ST_WR)) begin
      hold_cnt_next = hold_cnt_reg;
      if (rd_req && (hold_cnt_reg < HOLD_MAX)) begin
        hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
      end
    end

    // Registered copy of the current-cycle condition, so yield trails the
    // counter by one cycle and drops one cycle after the TURN state.
    yield_next = (hold_cnt_reg == HOLD_MAX) && (state_reg == ST_WR);
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      last_owner_reg <= OWNER_WR;
      hold_cnt_reg   <= '0;
      rd_gnt_reg     <= 1'b0;
      wr_gnt_reg     <= 1'b0;
      wr_yield_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      hold_cnt_reg   <= hold_cnt_next;
      rd_gnt_reg     <= grant_rd;
      wr_gnt_reg     <= grant_wr;
      wr_yield_reg   <= yield_next;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs and RAM mux. fb_we is decoded from the state register, so the
  // asynchronous reset forces it low immediately.
  // --------------------------------------------------------------------------
  assign rd_gnt   = rd_gnt_reg;
  assign wr_gnt   = wr_gnt_reg;
  assign wr_yield = wr_yield_reg;

  assign fb_addr  = (state_reg == ST_WR) ? wr_addr : rd_addr;
  assign fb_we    = (state_reg == ST_WR) && wr_ena;
  assign fb_wdata = wr_data;
  assign rd_data  = fb_rdata;

endmodule

// File: tb/tb_hub75_fb_arbiter.sv
module tb_hub75_fb_arbiter;

  localparam int AW = 13;
  localparam int DW = 16;
  localparam int NV = 25;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req, rd_gnt, rd_rel;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_req, wr_gnt, wr_rel;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ena, wr_yield;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_wdata;
  logic          fb_we;
  logic [DW-1:0] fb_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hub75_fb_arbiter #(
    .FB_AW(AW), .FB_DW(DW), .WR_MAX_BURST(4)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_rel(rd_rel),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_req(wr_req), .wr_gnt(wr_gnt), .wr_rel(wr_rel),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ena(wr_ena),
    .wr_yield(wr_yield),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we),
    .fb_rdata(fb_rdata)
  );

  typedef struct {
    logic          rr, wq, rrel, wrel, ena;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd, rdat;
    logic          e_rg, e_wg, e_y, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rd, e_wd;
  } vec_t;

  vec_t vecs [NV];
  vec_t sb_q [$];

  function automatic vec_t mk(input logic rr, wq, rrel, wrel, ena,
                              input logic [AW-1:0] ra, wa,
                              input logic [DW-1:0] wd,
                              input logic e_rg, e_wg, e_y, e_we,
                              input logic [AW-1:0] e_addr);
    vec_t v;
    v.rr = rr; v.wq = wq; v.rrel = rrel; v.wrel = wrel; v.ena = ena;
    v.ra = ra; v.wa = wa; v.wd = wd; v.rdat = 16'hA000 ^ {3'b0, ra};
    v.e_rg = e_rg; v.e_wg = e_wg; v.e_y = e_y; v.e_we = e_we;
    v.e_addr = e_addr;
    v.e_rd = v.rdat;  // read data passes straight through
    v.e_wd = wd;      // write data passes straight through
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rd_req = v.rr; wr_req = v.wq; rd_rel = v.rrel; wr_rel = v.wrel;
    wr_ena = v.ena; rd_addr = v.ra; wr_addr = v.wa; wr_data = v.wd;
    fb_rdata = v.rdat;
  endtask

  task automatic pop_and_check(input int idx);
    vec_t e;
    if (sb_q.size() == 0) begin
      chk($sformatf("v%0d_scoreboard_empty", idx), 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk($sformatf("v%0d_rd_gnt", idx),   {31'd0, rd_gnt},   {31'd0, e.e_rg});
    chk($sformatf("v%0d_wr_gnt", idx),   {31'd0, wr_gnt},   {31'd0, e.e_wg});
    chk($sformatf("v%0d_wr_yield", idx), {31'd0, wr_yield}, {31'd0, e.e_y});
    chk($sformatf("v%0d_fb_we", idx),    {31'd0, fb_we},    {31'd0, e.e_we});
    chk($sformatf("v%0d_fb_addr", idx),  {19'd0, fb_addr},  {19'd0, e.e_addr});
    chk($sformatf("v%0d_rd_data", idx),  {16'd0, rd_data},  {16'd0, e.e_rd});
    chk($sformatf("v%0d_fb_wdata", idx), {16'd0, fb_wdata}, {16'd0, e.e_wd});
    $display("vec %0d: rr=%0b wq=%0b rrel=%0b wrel=%0b ena=%0b -> rg=%0b wg=%0b y=%0b we=%0b addr=%h",
             idx, rd_req, wr_req, rd_rel, wr_rel, wr_ena, rd_gnt, wr_gnt, wr_yield, fb_we, fb_addr);
  endtask

  initial begin
    //                 rr wq rl wl en  rd_addr  wr_addr  wr_data   rg wg y  we  exp_addr
    vecs[0]  = mk(1, 1, 0, 0, 0, 13'h0010, 13'h0000, 16'h0000, 0, 0, 0, 0, 13'h0010);
    vecs[1]  = mk(1, 1, 0, 0, 0, 13'h0011, 13'h0000, 16'h0000, 1, 0, 0, 0, 13'h0011);
    vecs[2]  = mk(0, 1, 1, 0, 0, 13'h0012, 13'h0000, 16'h0000, 0, 0, 0, 0, 13'h0012);
    vecs[3]  = mk(0, 1, 0, 0, 1, 13'h0013, 13'h00AA, 16'h5555, 0, 0, 0, 0, 13'h0013);
    vecs[4]  = mk(0, 1, 0, 0, 1, 13'h1AAA, 13'h0123, 16'hBEEF, 0, 1, 0, 1, 13'h0123);
    vecs[5]  = mk(0, 0, 0, 0, 1, 13'h1AAA, 13'h0456, 16'h1234, 0, 0, 0, 1, 13'h0456);
    vecs[6]  = mk(0, 0, 0, 0, 0, 13'h1AAA, 13'h0457, 16'h0000, 0, 0, 0, 0, 13'h0457);
    vecs[7]  = mk(1, 0, 0, 0, 0, 13'h0020, 13'h0458, 16'h0000, 0, 0, 0, 0, 13'h0458);
    vecs[8]  = mk(1, 0, 0, 0, 1, 13'h0021, 13'h0459, 16'h0009, 0, 0, 0, 1, 13'h0459);
    vecs[9]  = mk(1, 0, 0, 0, 0, 13'h0022, 13'h045A, 16'h0000, 0, 0, 0, 0, 13'h045A);
    vecs[10] = mk(1, 0, 0, 0, 0, 13'h0023, 13'h045B, 16'h0000, 0, 0, 0, 0, 13'h045B);
    vecs[11] = mk(1, 0, 0, 0, 0, 13'h0024, 13'h045C, 16'h0000, 0, 0, 0, 0, 13'h045C);
    vecs[12] = mk(1, 0, 0, 0, 0, 13'h0025, 13'h045D, 16'h0000, 0, 0, 1, 0, 13'h045D);
    vecs[13] = mk(1, 0, 0, 1, 0, 13'h0026, 13'h045E, 16'h0000, 0, 0, 1, 0, 13'h045E);
    vecs[14] = mk(1, 0, 0, 0, 1, 13'h0030, 13'h045F, 16'h0000, 0, 0, 1, 0, 13'h0030);
    vecs[15] = mk(1, 0, 0, 1, 0, 13'h0031, 13'h0460, 16'h0000, 1, 0, 0, 0, 13'h0031);
    vecs[16] = mk(0, 1, 0, 1, 1, 13'h0032, 13'h0461, 16'h0000, 0, 0, 0, 0, 13'h0032);
    vecs[17] = mk(0, 1, 1, 0, 0, 13'h0033, 13'h0462, 16'h0000, 0, 0, 0, 0, 13'h0033);
    vecs[18] = mk(1, 1, 0, 0, 0, 13'h0034, 13'h0463, 16'h0000, 0, 0, 0, 0, 13'h0034);
    vecs[19] = mk(1, 1, 0, 1, 0, 13'h0035, 13'h0464, 16'h0000, 0, 1, 0, 0, 13'h0464);
    vecs[20] = mk(1, 0, 0, 0, 0, 13'h0036, 13'h0465, 16'h0000, 0, 0, 0, 0, 13'h0036);
    vecs[21] = mk(1, 0, 1, 0, 0, 13'h0037, 13'h0466, 16'h0000, 1, 0, 0, 0, 13'h0037);
    vecs[22] = mk(0, 0, 0, 0, 0, 13'h0038, 13'h0467, 16'h0000, 0, 0, 0, 0, 13'h0038);
    vecs[23] = mk(0, 1, 0, 0, 0, 13'h0039, 13'h0468, 16'h0000, 0, 0, 0, 0, 13'h0039);
    vecs[24] = mk(0, 1, 0, 0, 1, 13'h003A, 13'h0777, 16'hCAFE, 0, 1, 0, 1, 13'h0777);

    // Reset with both requests and a write strobe present: nothing may grant.
    rst = 1'b1;
    rd_req = 1'b1; wr_req = 1'b1; rd_rel = 1'b0; wr_rel = 1'b0;
    wr_ena = 1'b1; rd_addr = 13'h0005; wr_addr = 13'h0006;
    wr_data = 16'h0000; fb_rdata = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_rd_gnt",   {31'd0, rd_gnt},   32'd0);
    chk("reset_wr_gnt",   {31'd0, wr_gnt},   32'd0);
    chk("reset_wr_yield", {31'd0, wr_yield}, 32'd0);
    chk("reset_fb_we",    {31'd0, fb_we},    32'd0);
    chk("reset_fb_addr",  {19'd0, fb_addr},  32'h0005);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      sb_q.push_back(vecs[i]);
      #2;
      pop_and_check(i);
      @(negedge clk);
    end

    // Writer still owns here; assert reset mid-cycle and expect fb_we to drop
    // at once, without waiting for a clock edge.
    rd_req = 1'b0; wr_req = 1'b0; rd_rel = 1'b0; wr_rel = 1'b0;
    wr_ena = 1'b1; wr_addr = 13'h0777; rd_addr = 13'h0040;
    #1;
    chk("pre_rst_fb_we", {31'd0, fb_we}, 32'd1);
    $display("mid-session: fb_we=%0b before async reset", fb_we);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_fb_we",   {31'd0, fb_we},   32'd0);
    chk("async_rst_fb_addr", {19'd0, fb_addr}, 32'h0040);
    chk("async_rst_wr_gnt",  {31'd0, wr_gnt},  32'd0);
    $display("async reset: fb_we=%0b fb_addr=%h", fb_we, fb_addr);

    @(negedge clk);
    rst = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1; wr_ena = 1'b0;
    #1;
    chk("post_rst_idle_rd_gnt", {31'd0, rd_gnt}, 32'd0);
    @(negedge clk);
    #1;
    chk("post_rst_tie_rd_gnt", {31'd0, rd_gnt}, 32'd1);
    chk("post_rst_tie_wr_gnt", {31'd0, wr_gnt}, 32'd0);
    $display("after reset tie: rd_gnt=%0b wr_gnt=%0b", rd_gnt, wr_gnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
